// File: rtl/bsg_link_iddr_phy_align.sv
// DDR input word aligner: pairs posedge/negedge samples into 2*width_p words and slips the
// pairing phase until a training pattern is found. BSG_LINK_IDDR_PHY_ALIGN_ERR_CNT_EN adds err_cnt_o.
module bsg_link_iddr_phy_align #(
   parameter int unsigned                  width_p         = 16,
   parameter int unsigned                  lock_count_p    = 8,
   parameter int unsigned                  slip_window_p   = 4,
   parameter logic [2*width_p-1:0]         train_pattern_p = {width_p{2'b01}}
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic [width_p-1:0]   data_i,
   input  logic                 align_en_i,
   input  logic                 realign_i,
   output logic [2*width_p-1:0] data_r_o,
   output logic                 phase_o,
   output logic                 locked_o
`ifdef BSG_LINK_IDDR_PHY_ALIGN_ERR_CNT_EN
   ,
   output logic [15:0]          err_cnt_o
`endif
);

   localparam int unsigned max_cnt_lp =
      (lock_count_p > slip_window_p) ? lock_count_p : slip_window_p;
   localparam int unsigned cnt_w_lp = $clog2(max_cnt_lp + 1);
   localparam logic [cnt_w_lp-1:0] lock_cnt_lp = cnt_w_lp'(lock_count_p);
   localparam logic [cnt_w_lp-1:0] slip_cnt_lp = cnt_w_lp'(slip_window_p);
   localparam logic [cnt_w_lp-1:0] cnt_one_lp  = cnt_w_lp'(1);

   typedef enum logic [1:0] {StSearch, StFlush, StLocked} state_e;

   state_e                 state_q, state_d;
   logic [cnt_w_lp-1:0]    match_q, match_d;
   logic [cnt_w_lp-1:0]    miss_q, miss_d;
   logic                   flush_q, flush_d;
   logic                   phase_q, phase_d;
   logic [width_p-1:0]     p_q, n_q, n_prev_q;
   logic [2*width_p-1:0]   data_r_q, data_r_d;
   logic                   word_match;

   // Phase 1 pairs the previous negedge sample (low) with the following posedge sample (high).
   always_comb begin
      data_r_d = phase_q ? {p_q, n_prev_q} : {n_q, p_q};
   end

   assign word_match = (data_r_q == train_pattern_p);

   always_comb begin
      state_d = state_q;
      match_d = match_q;
      miss_d  = miss_q;
      flush_d = flush_q;
      phase_d = phase_q;
      if (realign_i) begin
         state_d = StSearch;
         match_d = '0;
         miss_d  = '0;
         flush_d = 1'b0;
      end else if (align_en_i) begin
         unique case (state_q)
            StSearch: begin
               if (match_q >= lock_cnt_lp) begin
                  state_d = StLocked;
                  match_d = '0;
                  miss_d  = '0;
               end else if (word_match) begin
                  miss_d  = '0;
                  match_d = (match_q == '1) ? match_q : match_q + cnt_one_lp;
               end else begin
                  match_d = '0;
                  if (miss_q + cnt_one_lp >= slip_cnt_lp) begin
                     phase_d = ~phase_q;
                     miss_d  = '0;
                     flush_d = 1'b0;
                     state_d = StFlush;
                  end else begin
                     miss_d = miss_q + cnt_one_lp;
                  end
               end
            end
            // Two cycles for the output register to refill with the new pairing.
            StFlush: begin
               if (flush_q) begin
                  flush_d = 1'b0;
                  state_d = StSearch;
               end else begin
                  flush_d = 1'b1;
               end
            end
            StLocked: ;
            default: state_d = StSearch;
         endcase
      end
   end

   always_ff @(negedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) n_q <= '0;
      else            n_q <= data_i;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         p_q      <= '0;
         n_prev_q <= '0;
         data_r_q <= '0;
         state_q  <= StSearch;
         match_q  <= '0;
         miss_q   <= '0;
         flush_q  <= 1'b0;
         phase_q  <= 1'b0;
      end else begin
         p_q      <= data_i;
         n_prev_q <= n_q;
         data_r_q <= data_r_d;
         state_q  <= state_d;
         match_q  <= match_d;
         miss_q   <= miss_d;
         flush_q  <= flush_d;
         phase_q  <= phase_d;
      end
   end

   assign data_r_o = data_r_q;
   assign phase_o  = phase_q;
   assign locked_o = (state_q == StLocked);

`ifdef BSG_LINK_IDDR_PHY_ALIGN_ERR_CNT_EN
   logic [15:0] err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (realign_i) begin
         err_d = '0;
      end else if (state_q == StLocked && align_en_i && !word_match && err_q != 16'hFFFF) begin
         err_d = err_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) err_q <= '0;
      else            err_q <= err_d;
   end

   assign err_cnt_o = err_q;
`endif

endmodule

// File: tb/tb_bsg_link_iddr_phy_align.sv
// Directed bench for bsg_link_iddr_phy_align: datapath tables in both phases plus lock, slip,
// realign, freeze and async-reset sequences; err counter checked when its macro is defined.
module tb_bsg_link_iddr_phy_align;

   localparam logic [31:0] Pat  = 32'h1234_ABCD;
   localparam logic [15:0] PatP = 16'hABCD;  // low half, sent on posedge when aligned
   localparam logic [15:0] PatN = 16'h1234;

   logic        clk_i = 1'b0;
   logic        reset_n_i;
   logic [15:0] data_i;
   logic        align_en_i;
   logic        realign_i;
   logic [31:0] data_r_o;
   logic        phase_o;
   logic        locked_o;
`ifdef BSG_LINK_IDDR_PHY_ALIGN_ERR_CNT_EN
   logic [15:0] err_cnt_o;
`endif

   int total = 0;
   int bad   = 0;

   bsg_link_iddr_phy_align #(
      .width_p         (16),
      .lock_count_p    (8),
      .slip_window_p   (4),
      .train_pattern_p (Pat)
   ) dut (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .data_i     (data_i),
      .align_en_i (align_en_i),
      .realign_i  (realign_i),
      .data_r_o   (data_r_o),
      .phase_o    (phase_o),
      .locked_o   (locked_o)
`ifdef BSG_LINK_IDDR_PHY_ALIGN_ERR_CNT_EN
      ,
      .err_cnt_o  (err_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [15:0] pos;
      logic [15:0] neg;
      logic [31:0] exp0;  // {neg_i, pos_i}
      logic [31:0] exp1;  // {pos_i, neg_(i-1)}
   } vec_t;

   vec_t tbl[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called just after a posedge; returns 2 time units after the next posedge (E_k), where pos
   // was sampled, with neg already driven for the following negedge.
   task automatic cyc(input logic [15:0] pos, input logic [15:0] neg);
      @(negedge clk_i);
      #2 data_i = pos;
      @(posedge clk_i);
      #2 data_i = neg;
   endtask

   task automatic do_reset();
      reset_n_i  = 1'b0;
      align_en_i = 1'b0;
      realign_i  = 1'b0;
      data_i     = '0;
      repeat (2) @(posedge clk_i);
      #2 reset_n_i = 1'b1;
   endtask

   task automatic run_table(input bit ph);
      for (int i = 0; i < 5; i++) begin
         cyc(tbl[i].pos, tbl[i].neg);
         if (i > 0) check(ph ? "tbl_ph1" : "tbl_ph0", data_r_o, ph ? tbl[i-1].exp1 : tbl[i-1].exp0);
         check("tbl_locked", {31'b0, locked_o}, {31'b0, ph});
         check("tbl_phase", {31'b0, phase_o}, {31'b0, ph});
      end
      cyc(PatN, PatP);
      check(ph ? "tbl_ph1_last" : "tbl_ph0_last", data_r_o, ph ? tbl[4].exp1 : tbl[4].exp0);
   endtask

   initial begin
      tbl[0] = '{16'h0001, 16'h8000, 32'h8000_0001, 32'h0001_ABCD};
      tbl[1] = '{16'hFFFF, 16'h0000, 32'h0000_FFFF, 32'hFFFF_8000};
      tbl[2] = '{16'hA5A5, 16'h5A5A, 32'h5A5A_A5A5, 32'hA5A5_0000};
      tbl[3] = '{16'h1234, 16'hABCD, 32'hABCD_1234, 32'h1234_5A5A};
      tbl[4] = '{16'hABCD, 16'h1234, 32'h1234_ABCD, 32'hABCD_ABCD};

      // Reset values
      reset_n_i = 1'b0;
      align_en_i = 1'b0;
      realign_i = 1'b0;
      data_i = '0;
      #1;
      check("rst_data", data_r_o, 32'h0);
      check("rst_locked", {31'b0, locked_o}, 32'h0);
      check("rst_phase", {31'b0, phase_o}, 32'h0);
`ifdef BSG_LINK_IDDR_PHY_ALIGN_ERR_CNT_EN
      check("rst_err", {16'b0, err_cnt_o}, 32'h0);
`endif

      // Phase-0 datapath with training disabled: FSM must stay frozen
      do_reset();
      run_table(1'b0);

      // Aligned pattern: first word sampled at E_0, locked after E_10
      do_reset();
      align_en_i = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         cyc(PatP, PatN);
         if (k == 9)  check("align_lock_early", {31'b0, locked_o}, 32'h0);
         if (k == 10) check("align_lock", {31'b0, locked_o}, 32'h1);
         if (k == 10) check("align_phase", {31'b0, phase_o}, 32'h0);
      end

      // Half-cycle offset: slip at E_3, flush E_4..E_5, matches E_6..E_13, lock at E_14
      do_reset();
      align_en_i = 1'b1;
      for (int k = 0; k <= 14; k++) begin
         cyc(PatN, PatP);
         if (k == 2)  check("off_phase_pre", {31'b0, phase_o}, 32'h0);
         if (k == 3)  check("off_phase_slip", {31'b0, phase_o}, 32'h1);
         if (k == 13) check("off_lock_early", {31'b0, locked_o}, 32'h0);
         if (k == 14) check("off_lock", {31'b0, locked_o}, 32'h1);
      end

      // Phase-1 datapath while locked: data content is ignored
      run_table(1'b1);
      cyc(PatN, PatP);

      // Realign with training disabled: drop lock, keep phase, stay frozen
      align_en_i = 1'b0;
      realign_i  = 1'b1;
      cyc(PatN, PatP);
      realign_i  = 1'b0;
      check("realign_locked", {31'b0, locked_o}, 32'h0);
      check("realign_phase", {31'b0, phase_o}, 32'h1);
      for (int k = 0; k < 10; k++) begin
         cyc(PatN, PatP);
         check("frozen_locked", {31'b0, locked_o}, 32'h0);
      end
      align_en_i = 1'b1;
      repeat (8) cyc(PatN, PatP);
      check("relock_early", {31'b0, locked_o}, 32'h0);
      cyc(PatN, PatP);
      check("relock", {31'b0, locked_o}, 32'h1);
      check("relock_phase", {31'b0, phase_o}, 32'h1);

      // Asynchronous reset between edges while locked
      #1 reset_n_i = 1'b0;
      #1;
      check("async_data", data_r_o, 32'h0);
      check("async_locked", {31'b0, locked_o}, 32'h0);
      check("async_phase", {31'b0, phase_o}, 32'h0);

      // Random data: phase toggles at E_3, E_9, E_15, E_21; never locks
      do_reset();
      align_en_i = 1'b1;
      for (int k = 0; k < 24; k++) begin
         int exp_ph;
         cyc(16'($urandom), 16'($urandom));
         exp_ph = (k < 3) ? 0 : ((((k - 3) / 6) + 1) & 1);
         check("rand_phase", {31'b0, phase_o}, 32'(exp_ph));
         check("rand_locked", {31'b0, locked_o}, 32'h0);
      end

`ifdef BSG_LINK_IDDR_PHY_ALIGN_ERR_CNT_EN
      do_reset();
      align_en_i = 1'b1;
      repeat (11) cyc(PatP, PatN);
      check("err_locked", {31'b0, locked_o}, 32'h1);
      check("err_zero", {16'b0, err_cnt_o}, 32'h0);
      repeat (3) cyc(16'h0000, PatN);
      repeat (4) cyc(PatP, PatN);
      check("err_three", {16'b0, err_cnt_o}, 32'd3);
      realign_i = 1'b1;
      cyc(PatP, PatN);
      realign_i = 1'b0;
      check("err_clear", {16'b0, err_cnt_o}, 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
